// File: rtl/l2_pkg.sv
// Shared constants and FSM encoding for the L2 line responder.
package l2_pkg;
   localparam int ADDR_WIDTH   = 32;
   localparam int DATA_WIDTH   = 32;
   localparam int B_DEF        = 9;
   localparam int W_DEF        = 7;
   localparam int L2_BUS_WIDTH = 1 << W_DEF;
   localparam int L2_BURST     = 1 << (B_DEF - W_DEF);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
   } l2_state_e;
endpackage

// File: rtl/l2_line_ram.sv
// Single-clock line RAM: one write port, one registered read-first read port.
// Contents are not reset; the read register holds when no read is issued.
module l2_line_ram #(
   parameter int AW = 12,
   parameter int DW = 128
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [DW-1:0] r_rdata;

   // Write and read in one process so a same-index read sees the old word
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/l2_line_responder.sv
// L2-side responder for the I-cache miss port: queues line requests, waits a
// fixed latency, then streams each block as aligned bus-wide beats.
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both high. VALID, once raised, stays high with stable data until accepted.
module l2_line_responder
   import l2_pkg::*;
#(
   parameter int B        = B_DEF,
   parameter int W        = W_DEF,
   parameter int L2_DELAY = 7,
   parameter int MEM_AW   = 12,
   parameter int FIFO_AW  = 2
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic [ADDR_WIDTH-3:0] ADDR_TO_L2,
   input  logic                  ADDR_TO_L2_VALID,
   output logic                  ADDR_TO_L2_READY,
   output logic [(1<<W)-1:0]     DATA_FROM_L2,
   output logic                  DATA_FROM_L2_VALID,
   input  logic                  DATA_FROM_L2_READY,
   input  logic                  MEM_WR_EN,
   input  logic [MEM_AW-1:0]     MEM_WR_ADDR,
   input  logic [(1<<W)-1:0]     MEM_WR_DATA,
   output logic [1:0]            o_dbg_state
);
   localparam int BUS_W  = 1 << W;
   localparam int BEAT_W = B - W;
   localparam int OFS_W  = B - $clog2(DATA_WIDTH);
   localparam int TAG_W  = ADDR_WIDTH - 2 - OFS_W;
   localparam int LINE_W = TAG_W + BEAT_W;
   localparam int DEPTH  = 1 << FIFO_AW;
   localparam int CNT_W  = $clog2(L2_DELAY);

   localparam logic [BEAT_W-1:0]  BEAT_ONE  = 1;
   localparam logic [BEAT_W-1:0]  LAST_BEAT = '1;
   localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
   localparam logic [FIFO_AW:0]   CNT_ONE   = 1;
   localparam logic [FIFO_AW:0]   FULL_CNT  = DEPTH[FIFO_AW:0];
   localparam logic [CNT_W-1:0]   DLY_ONE   = 1;
   // From IDLE the pop lands one edge after eligibility; from BURST it lands on it.
   localparam logic [CNT_W-1:0]   DLY_IDLE  = CNT_W'(L2_DELAY - 2);
   localparam logic [CNT_W-1:0]   DLY_CHAIN = CNT_W'(L2_DELAY - 1);

   // Request FIFO
   logic [TAG_W-1:0]   r_fifo [0:DEPTH-1];
   logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [FIFO_AW:0]   r_count, w_count_nxt;
   logic               r_ready;
   logic               w_push, w_pop, w_empty;
   logic [TAG_W-1:0]   w_req_tag;

   // Burst engine
   l2_state_e          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [BEAT_W-1:0]  r_beat;
   logic [TAG_W-1:0]   r_tag;
   logic               r_valid;
   logic               w_hs, w_last_hs, w_rd_en;
   logic [BEAT_W-1:0]  w_rd_beat;
   logic [LINE_W-1:0]  w_line;
   logic [MEM_AW-1:0]  w_rd_addr;
   logic [BUS_W-1:0]   w_ram_q;
   logic               w_unused;

   assign w_req_tag = ADDR_TO_L2[ADDR_WIDTH-3:OFS_W];
   assign w_push    = ADDR_TO_L2_VALID && r_ready;
   assign w_empty   = (r_count == '0);
   assign w_hs      = r_valid && DATA_FROM_L2_READY;
   assign w_last_hs = w_hs && (r_beat == LAST_BEAT);
   assign w_pop     = !w_empty && ((r_state == ST_IDLE) ||
                                   ((r_state == ST_BURST) && w_last_hs));

   // Beat 0 is read on the last WAIT cycle; later beats are fetched on the
   // handshake of the previous one so the next word is ready without a bubble.
   assign w_rd_beat = (r_state == ST_WAIT) ? '0 : (r_beat + BEAT_ONE);
   assign w_rd_en   = ((r_state == ST_WAIT) && (r_cnt == '0)) || (w_hs && !w_last_hs);
   assign w_line    = {r_tag, w_rd_beat};
   assign w_rd_addr = w_line[MEM_AW-1:0];
   assign w_unused  = ^{ADDR_TO_L2[OFS_W-1:0], w_line[LINE_W-1:MEM_AW]};

   // Next FIFO occupancy
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + CNT_ONE;
      else if (!w_push && w_pop) w_count_nxt = r_count - CNT_ONE;
   end

   // FIFO storage write (data only, no reset needed)
   always_ff @(posedge CLK) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_req_tag;
   end

   // FIFO pointers, occupancy and registered READY
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt != FULL_CNT);
      end
   end

   // Request sequencing: IDLE -> WAIT (latency) -> BURST (beats) -> IDLE/WAIT
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_tag   <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_tag   <= r_fifo[r_rd_ptr];
                  r_cnt   <= DLY_IDLE;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= ST_BURST;
                  r_valid <= 1'b1;
                  r_beat  <= '0;
               end else begin
                  r_cnt <= r_cnt - DLY_ONE;
               end
            end
            ST_BURST: begin
               if (w_last_hs) begin
                  r_valid <= 1'b0;
                  r_beat  <= '0;
                  if (!w_empty) begin
                     r_tag   <= r_fifo[r_rd_ptr];
                     r_cnt   <= DLY_CHAIN;
                     r_state <= ST_WAIT;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else if (w_hs) begin
                  r_beat <= r_beat + BEAT_ONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   l2_line_ram #(
      .AW (MEM_AW),
      .DW (BUS_W)
   ) u_ram (
      .clk     (CLK),
      .i_we    (MEM_WR_EN),
      .i_waddr (MEM_WR_ADDR),
      .i_wdata (MEM_WR_DATA),
      .i_re    (w_rd_en),
      .i_raddr (w_rd_addr),
      .o_rdata (w_ram_q)
   );

   assign ADDR_TO_L2_READY   = r_ready;
   assign DATA_FROM_L2_VALID = r_valid;
   // RAM output is uninitialised and not reset; show zero whenever no beat is offered
   assign DATA_FROM_L2       = r_valid ? w_ram_q : '0;
   assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder: vector table of single bursts plus
// hand-written sequences for RAM collisions, queue-full and mid-burst reset.
module tb_l2_line_responder;
   import l2_pkg::*;

   localparam int N_BEAT = 4;
   localparam int DLY    = 7;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [29:0]  addr = '0;
   logic         addr_valid = 1'b0;
   logic         addr_ready;
   logic [127:0] data;
   logic         data_valid;
   logic         data_ready = 1'b1;
   logic         mem_we = 1'b0;
   logic [11:0]  mem_wa = '0;
   logic [127:0] mem_wd = '0;
   logic [1:0]   dbg_state;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   logic [127:0] mem_model [0:4095];

   typedef struct {
      logic [29:0] addr;
      int          stall_at;
      int          stall_n;
      int          exp_line;
      int          exp_span;
   } vec_t;
   vec_t vecs [6];

   l2_line_responder dut (
      .CLK                (clk),
      .RSTN               (rstn),
      .ADDR_TO_L2         (addr),
      .ADDR_TO_L2_VALID   (addr_valid),
      .ADDR_TO_L2_READY   (addr_ready),
      .DATA_FROM_L2       (data),
      .DATA_FROM_L2_VALID (data_valid),
      .DATA_FROM_L2_READY (data_ready),
      .MEM_WR_EN          (mem_we),
      .MEM_WR_ADDR        (mem_wa),
      .MEM_WR_DATA        (mem_wd),
      .o_dbg_state        (dbg_state)
   );

   // clock / edge counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load_line(input int line, input logic [127:0] d);
      mem_we = 1'b1;
      mem_wa = 12'(line);
      mem_wd = d;
      @(negedge clk);
      mem_we = 1'b0;
      mem_model[12'(line)] = d;
   endtask

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic send_req(input logic [29:0] a, output int acc_cyc);
      addr = a;
      addr_valid = 1'b1;
      acc_cyc = -1;
      for (int t = 0; t < 200; t++) begin
         if (addr_ready) begin
            @(negedge clk);
            acc_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc_cyc < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL req accept: READY never seen for addr %h", a);
      end
   endtask

   task automatic wait_valid(input string name, output int at);
      at = -1;
      for (int t = 0; t < 100; t++) begin
         if (data_valid) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
      if (at < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: no beat valid within 100 cycles", name);
      end
   endtask

   // called at the negedge where beat 0 is first offered
   task automatic take_burst(input string name, input int base, input int stall_at,
                             input int stall_n, output int last);
      for (int k = 0; k < N_BEAT; k++) begin
         if (k == stall_at) begin
            data_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               check({name, " stall valid"}, 128'(data_valid), 128'(1));
               check({name, " stall data"}, data, mem_model[12'(base + k)]);
               @(negedge clk);
            end
         end
         data_ready = 1'b1;
         check({name, " beat valid"}, 128'(data_valid), 128'(1));
         check({name, " beat data"}, data, mem_model[12'(base + k)]);
         @(negedge clk);
      end
      last = cyc;
   endtask

   initial begin
      int acc, first, last;
      int acc6 [6];
      int first6 [6];
      int last6 [6];
      logic [29:0] q_addr [6];
      int q_base [6];
      logic [127:0] old41, new41, new43;
      int stale;

      vecs[0] = '{30'h100,       -1, 0, 'h40, 4};
      vecs[1] = '{30'h10B,       -1, 0, 'h40, 4};
      vecs[2] = '{30'h100,        1, 3, 'h40, 7};
      vecs[3] = '{30'h3FFF_0100, -1, 0, 'h40, 4};
      vecs[4] = '{30'h140,        2, 1, 'h50, 5};
      vecs[5] = '{30'h1FF,        0, 2, 'h7C, 6};

      // reset state
      repeat (3) @(negedge clk);
      check("reset ready", 128'(addr_ready), 128'(0));
      check("reset valid", 128'(data_valid), 128'(0));
      check("reset data", data, 128'(0));
      check("reset state", 128'(dbg_state), 128'(ST_IDLE));
      rstn = 1'b1;
      @(negedge clk);
      check("ready after reset", 128'(addr_ready), 128'(1));

      // RAM image
      for (int ln = 'h3C; ln < 'h80; ln++) begin
         if (ln >= 'h40 && ln <= 'h43)
            load_line(ln, {32'hA5A5_A5A5, 32'h0, 32'hC3C3_C3C3, 32'hA0 + 32'(ln - 'h40)});
         else
            load_line(ln, {16'hBEEF, 16'(ln), 32'h5A5A_0000 + 32'(ln), 32'hC3C3_C3C3, 32'hF000 + 32'(ln)});
      end
      repeat (2) @(negedge clk);

      // table-driven single bursts
      for (int i = 0; i < 6; i++) begin
         send_req(vecs[i].addr, acc);
         addr_valid = 1'b0;
         wait_valid("vec first beat", first);
         check("vec latency", 128'(first - acc), 128'(DLY));
         take_burst("vec", vecs[i].exp_line, vecs[i].stall_at, vecs[i].stall_n, last);
         check("vec span", 128'(last - first), 128'(vecs[i].exp_span));
         check("vec valid after burst", 128'(data_valid), 128'(0));
         repeat (3) @(negedge clk);
      end

      // RAM collision: same-cycle write/read returns old data; mid-burst write seen later
      old41 = mem_model[12'h41];
      new41 = 128'h4141_4141_0000_0000_1111_2222_3333_0041;
      new43 = 128'h4343_4343_0000_0000_5555_6666_7777_0043;
      send_req(30'h100, acc);
      addr_valid = 1'b0;
      wait_valid("rfirst first beat", first);
      check("rfirst beat0", data, mem_model[12'h40]);
      data_ready = 1'b1;
      mem_we = 1'b1; mem_wa = 12'h41; mem_wd = new41;
      @(negedge clk);
      mem_we = 1'b0;
      check("rfirst beat1 old", data, old41);
      data_ready = 1'b0;
      mem_we = 1'b1; mem_wa = 12'h43; mem_wd = new43;
      @(negedge clk);
      mem_we = 1'b0;
      check("rfirst beat1 held", data, old41);
      data_ready = 1'b1;
      @(negedge clk);
      check("rfirst beat2", data, mem_model[12'h42]);
      @(negedge clk);
      check("rfirst beat3 new", data, new43);
      @(negedge clk);
      check("rfirst valid end", 128'(data_valid), 128'(0));
      mem_model[12'h41] = new41;
      mem_model[12'h43] = new43;
      repeat (3) @(negedge clk);

      // re-read shows the updated line 0x41
      send_req(30'h100, acc);
      addr_valid = 1'b0;
      wait_valid("reread first beat", first);
      take_burst("reread", 'h40, -1, 0, last);
      repeat (3) @(negedge clk);

      // six back-to-back requests: five fit (one in flight + four queued)
      q_addr = '{30'h100, 30'h140, 30'h180, 30'h1C0, 30'h10B, 30'h1FF};
      q_base = '{'h40, 'h50, 'h60, 'h70, 'h40, 'h7C};
      fork
         begin
            for (int i = 0; i < 6; i++) send_req(q_addr[i], acc6[i]);
            addr_valid = 1'b0;
         end
         begin
            for (int j = 0; j < 6; j++) begin
               wait_valid("queue first beat", first6[j]);
               take_burst("queue", q_base[j], -1, 0, last6[j]);
            end
         end
      join
      for (int i = 1; i < 5; i++)
         check("queue accept back-to-back", 128'(acc6[i] - acc6[0]), 128'(i));
      check("queue 6th waits for pop", 128'(acc6[5] - last6[0]), 128'(1));
      check("queue first latency", 128'(first6[0] - acc6[0]), 128'(DLY));
      for (int i = 1; i < 6; i++)
         check("queue chained latency", 128'(first6[i] - last6[i-1]), 128'(DLY));
      check("queue valid end", 128'(data_valid), 128'(0));
      repeat (3) @(negedge clk);

      // reset during beat 2 with two requests queued
      send_req(30'h100, acc);
      send_req(30'h140, acc);
      send_req(30'h180, acc);
      addr_valid = 1'b0;
      wait_valid("rst first beat", first);
      data_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst beat2 before reset", data, mem_model[12'h42]);
      #2 rstn = 1'b0;
      #1;
      check("rst valid drop", 128'(data_valid), 128'(0));
      check("rst data zero", data, 128'(0));
      check("rst ready low", 128'(addr_ready), 128'(0));
      check("rst state idle", 128'(dbg_state), 128'(ST_IDLE));
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("rst ready after release", 128'(addr_ready), 128'(1));
      stale = 0;
      for (int t = 0; t < 30; t++) begin
         if (data_valid) stale++;
         @(negedge clk);
      end
      check("rst no stale beats", 128'(stale), 128'(0));
      send_req(30'h100, acc);
      addr_valid = 1'b0;
      wait_valid("post-rst first beat", first);
      check("post-rst latency", 128'(first - acc), 128'(DLY));
      take_burst("post-rst", 'h40, -1, 0, last);
      check("post-rst valid end", 128'(data_valid), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
